multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Moore-style multicycle controller for the RV32I subset core (lw, sw, R-type, I-ALU, beq/bne, jal, jalr). It sequences fetch/decode/execute/memory/writeback over a shared unified memory port fronted by the cache. It holds in memory states while the cache asserts Stall, and flags runaway stalls with a watchdog. It decodes ALUControl from an internal ALUOp, and resolves the branch decision itself to produce PCWrite.

Parameters:
EN_BNE, 1, 1 = bne (funct3 001) supported; 0 = bne never taken.
MAX_STALL, 64, consecutive Stall cycles in one wait state before stall_timeout sets (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
op  in  7  instruction[6:0] from IR.
funct3  in  3  instruction[14:12].
funct7  in  1  instruction[30].
Zero  in  1  ALU zero flag.
Stall  in  1  cache busy/miss; memory access not complete this cycle.
PCWrite  out  1  PC register enable.
AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
IRWrite  out  1  IR/OldPC enable.
MemRead  out  1  cache read request.
MemWrite  out  1  cache write request.
RegWrite  out  1  register-file write enable.
ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult.
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 data.
ALUSrcB  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4.
ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J; decoded from op in every state.
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
illegal_instr  out  1  one-cycle pulse on unsupported opcode.
instr_retired  out  1  one-cycle pulse on each completed instruction.
stall_timeout  out  1  sticky watchdog flag.
state_o  out  4  current state encoding, for debug.

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, JALR = 11, JLINK = 12, ILLEGAL = 13. Codes 14 and 15 go to FETCH.
- Reset, asynchronous:
  - state = FETCH, stall counter = 0, stall_timeout = 0.
  - While rst_n = 0, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal_instr and instr_retired are forced 0.
- Unlisted outputs default to 0 / add.
- FETCH:
  - AdrSrc = 0, MemRead = 1, ALUSrcA = 00, ALUSrcB = 10, add, ResultSrc = 10.
  - IRWrite = PCWrite = !Stall.
  - Next = DECODE when !Stall, else stay in FETCH.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, add (branch/jal target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - any other op -> ILLEGAL
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, add. Next = MEMREAD if op[5] = 0, else MEMWRITE.
- MEMREAD: AdrSrc = 1, ResultSrc = 00, MemRead = 1. Holds while Stall; else -> MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, instr_retired = 1. Next = FETCH.
- MEMWRITE: AdrSrc = 1, ResultSrc = 00, MemWrite = 1, held for the whole wait. When !Stall: instr_retired = 1, next = FETCH.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Next = ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Next = ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, instr_retired = 1. Next = FETCH.
- BRANCH:
  - ALUSrcA = 10, ALUSrcB = 00, sub, ResultSrc = 00.
  - PCWrite = (funct3 == 000 & Zero) | (EN_BNE & funct3 == 001 & !Zero).
  - instr_retired = 1. Next = FETCH.
- JAL: ResultSrc = 00, PCWrite = 1, ALUSrcA = 01, ALUSrcB = 10, add (link value). Next = ALUWB.
- JALR: ALUSrcA = 10, ALUSrcB = 01, add, ResultSrc = 10, PCWrite = 1. Next = JLINK.
- JLINK: ALUSrcA = 01, ALUSrcB = 10, add. Next = ALUWB.
- ILLEGAL: illegal_instr = 1, no writes. Next = FETCH; not counted as retired.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 by funct3:
    - 000 -> sub if {op[5], funct7} == 11, else add
    - 110 -> or
    - 111 -> and
    - 010 -> slt
    - any other funct3 -> add
- Stall watchdog:
  - The counter increments on each clk where the state is FETCH, MEMREAD or MEMWRITE and Stall = 1. It saturates at MAX_STALL.
  - It clears on any cycle where Stall = 0 or the state is any other.
  - stall_timeout sets on the edge where the count reaches MAX_STALL. It stays 1 until reset; the FSM keeps waiting.
- Stall is ignored in all non-memory states.
- Latency without stalls:
  - lw 5 cycles; sw 4; R/I-ALU 4; branch 3; jal 4; jalr 5; illegal 3.

Test Plan:
- Reset, then lw with Stall high for 3 cycles in FETCH and 2 in MEMREAD -> states 0,0,0,0,1,2,3,3,3,4,0. IRWrite/PCWrite assert only on the 4th FETCH cycle. A single RegWrite pulse in MEMWB; instr_retired pulses once.
- R-type with funct3 = 000, funct7 = 1 -> ALUControl = 001 in EXECR. The same with op = 0010011 (addi, funct7 bit set) -> 000. funct3 = 010 -> 101.
- beq with Zero = 1 -> PCWrite = 1 in BRANCH. bne with Zero = 0: PCWrite = 1 when EN_BNE = 1, PCWrite = 0 when EN_BNE = 0. State returns to 0 after 3 cycles in all cases.
- jalr -> states 1, 11, 12, 8, 0. PCWrite = 1 only in JALR with ResultSrc = 10. RegWrite = 1 in ALUWB.
- op = 0001111 -> ILLEGAL. illegal_instr pulses once, no write enables assert, instr_retired stays 0.
- MAX_STALL = 4, sw with Stall held 6 cycles in MEMWRITE -> stall_timeout rises after the 4th stalled cycle. MemWrite stays 1 throughout. Drop rst_n mid-wait -> outputs 0 immediately, state = 0, stall_timeout = 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Moore multicycle controller for the RV32I subset core: state sequencing, ALU decode,
// branch resolution and a stall watchdog for the shared cache-fronted memory port.
module multicycle_control_unit #(
  parameter logic EN_BNE    = 1'b1,
  parameter int   MAX_STALL = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       Stall,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_instr,
  output logic       instr_retired,
  output logic       stall_timeout,
  output logic [3:0] state_o
);

  localparam int CW = $clog2(MAX_STALL + 1);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE   = 4'd1,  MEMADR  = 4'd2,  MEMREAD = 4'd3,
    MEMWB    = 4'd4,  MEMWRITE = 4'd5,  EXECR   = 4'd6,  EXECI   = 4'd7,
    ALUWB    = 4'd8,  BRANCH   = 4'd9,  JAL     = 4'd10, JALR    = 4'd11,
    JLINK    = 4'd12, ILLEGAL  = 4'd13
  } state_t;

  state_t          state_r, next_s;
  logic [CW-1:0]   stall_cnt_r;
  logic            stall_timeout_r;
  logic [1:0]      alu_op_s;
  logic            pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;
  logic            illegal_s, retired_s, waiting_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    next_s      = FETCH;
    alu_op_s    = 2'b00;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    retired_s   = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    case (state_r)
      FETCH: begin
        mem_read_s = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_s = !Stall;
        pc_write_s = !Stall;
        next_s     = Stall ? FETCH : DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: next_s = MEMADR;
          7'b0110011:             next_s = EXECR;
          7'b0010011:             next_s = EXECI;
          7'b1100011:             next_s = BRANCH;
          7'b1101111:             next_s = JAL;
          7'b1100111:             next_s = JALR;
          default:                next_s = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next_s  = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        mem_read_s = 1'b1;
        next_s     = Stall ? MEMREAD : MEMWB;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
        retired_s   = 1'b1;
        next_s      = FETCH;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        retired_s   = !Stall;
        next_s      = Stall ? MEMWRITE : FETCH;
      end
      EXECR: begin
        ALUSrcA  = 2'b10;
        alu_op_s = 2'b10;
        next_s   = ALUWB;
      end
      EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        alu_op_s = 2'b10;
        next_s   = ALUWB;
      end
      ALUWB: begin
        reg_write_s = 1'b1;
        retired_s   = 1'b1;
        next_s      = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        alu_op_s   = 2'b01;
        pc_write_s = ((funct3 == 3'b000) && Zero) ||
                     (EN_BNE && (funct3 == 3'b001) && !Zero);
        retired_s  = 1'b1;
        next_s     = FETCH;
      end
      JAL: begin
        pc_write_s = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        next_s     = ALUWB;
      end
      JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        pc_write_s = 1'b1;
        next_s     = JLINK;
      end
      JLINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        next_s  = ALUWB;
      end
      ILLEGAL: begin
        illegal_s = 1'b1;
        next_s    = FETCH;
      end
      default: next_s = FETCH;
    endcase
  end

  // ALU operation decode from the internal ALUOp
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op_s)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = ({op[5], funct7} == 2'b11) ? 3'b001 : 3'b000;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          3'b010:  ALUControl = 3'b101;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  assign waiting_s = (state_r == FETCH) || (state_r == MEMREAD) || (state_r == MEMWRITE);

  // Watchdog: counts consecutive stalled wait cycles; the timeout flag is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r     <= '0;
      stall_timeout_r <= 1'b0;
    end else if (waiting_s && Stall) begin
      if (stall_cnt_r != CW'(MAX_STALL)) begin
        stall_cnt_r <= stall_cnt_r + CW'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (stall_cnt_r == CW'(MAX_STALL - 1)) begin
        stall_timeout_r <= 1'b1;
      end else begin
        stall_timeout_r <= stall_timeout_r;
      end
    end else begin
      stall_cnt_r     <= '0;
      stall_timeout_r <= stall_timeout_r;
    end
  end

  // Enables are killed combinationally so nothing writes while reset is held
  assign PCWrite       = pc_write_s  & rst_n;
  assign IRWrite       = ir_write_s  & rst_n;
  assign MemRead       = mem_read_s  & rst_n;
  assign MemWrite      = mem_write_s & rst_n;
  assign RegWrite      = reg_write_s & rst_n;
  assign illegal_instr = illegal_s   & rst_n;
  assign instr_retired = retired_s   & rst_n;
  assign stall_timeout = stall_timeout_r;
  assign state_o       = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; a second instance with bne disabled
// shares the same stimulus so the EN_BNE = 0 behaviour is observed alongside.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7, Zero, Stall;

  logic       PCWrite, AdrSrc, IRWrite, MemRead, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal_instr, instr_retired, stall_timeout;
  logic [3:0] state_o;

  logic       b_PCWrite, b_AdrSrc, b_IRWrite, b_MemRead, b_MemWrite, b_RegWrite;
  logic [1:0] b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ImmSrc;
  logic [2:0] b_ALUControl;
  logic       b_illegal_instr, b_instr_retired, b_stall_timeout;
  logic [3:0] b_state_o;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.EN_BNE(1'b1), .MAX_STALL(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .Stall(Stall), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal_instr(illegal_instr), .instr_retired(instr_retired),
    .stall_timeout(stall_timeout), .state_o(state_o)
  );

  multicycle_control_unit #(.EN_BNE(1'b0), .MAX_STALL(4)) dut_nobne (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .Stall(Stall), .PCWrite(b_PCWrite), .AdrSrc(b_AdrSrc),
    .IRWrite(b_IRWrite), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
    .RegWrite(b_RegWrite), .ResultSrc(b_ResultSrc), .ALUSrcA(b_ALUSrcA),
    .ALUSrcB(b_ALUSrcB), .ImmSrc(b_ImmSrc), .ALUControl(b_ALUControl),
    .illegal_instr(b_illegal_instr), .instr_retired(b_instr_retired),
    .stall_timeout(b_stall_timeout), .state_o(b_state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7 = 1'b0;
    Zero = 1'b0; Stall = 1'b1;
    #1;
    chk("rst_state", state_o, 32'd0);
    chk("rst_memread_forced", MemRead, 32'd0);
    chk("rst_irwrite", IRWrite, 32'd0);
    chk("rst_timeout", stall_timeout, 32'd0);
    #11 rst_n = 1'b1;
    #1;
    // lw: three stalled FETCH cycles, then a clean one
    chk("lw_f1_state", state_o, 32'd0);
    chk("lw_f1_memread", MemRead, 32'd1);
    chk("lw_f1_irwrite", IRWrite, 32'd0);
    tick(); chk("lw_f2_state", state_o, 32'd0); chk("lw_f2_pcwrite", PCWrite, 32'd0);
    tick(); chk("lw_f3_state", state_o, 32'd0); chk("lw_f3_irwrite", IRWrite, 32'd0);
    tick(); Stall = 1'b0; #1;
    chk("lw_f4_state", state_o, 32'd0);
    chk("lw_f4_irwrite", IRWrite, 32'd1);
    chk("lw_f4_pcwrite", PCWrite, 32'd1);
    chk("lw_f4_alusrcb", ALUSrcB, 32'd2);
    chk("lw_f4_resultsrc", ResultSrc, 32'd2);
    tick(); chk("lw_decode", state_o, 32'd1); chk("lw_dec_alusrca", ALUSrcA, 32'd1);
    chk("lw_immsrc", ImmSrc, 32'd0); chk("lw_dec_retired", instr_retired, 32'd0);
    Stall = 1'b1;
    tick(); chk("lw_memadr", state_o, 32'd2); chk("lw_memadr_srca", ALUSrcA, 32'd2);
    tick(); chk("lw_mr1", state_o, 32'd3); chk("lw_mr1_adrsrc", AdrSrc, 32'd1);
    chk("lw_mr1_memread", MemRead, 32'd1);
    tick(); chk("lw_mr2", state_o, 32'd3); chk("lw_mr2_regwrite", RegWrite, 32'd0);
    tick(); Stall = 1'b0; #1; chk("lw_mr3", state_o, 32'd3);
    tick(); chk("lw_memwb", state_o, 32'd4); chk("lw_wb_regwrite", RegWrite, 32'd1);
    chk("lw_wb_resultsrc", ResultSrc, 32'd1); chk("lw_wb_retired", instr_retired, 32'd1);
    op = 7'b0110011; funct3 = 3'b000; funct7 = 1'b1;
    tick(); chk("lw_done", state_o, 32'd0); chk("lw_done_regwrite", RegWrite, 32'd0);
    chk("lw_done_retired", instr_retired, 32'd0); chk("lw_no_timeout", stall_timeout, 32'd0);

    // R-type sub
    tick(); chk("sub_decode", state_o, 32'd1);
    tick(); chk("sub_execr", state_o, 32'd6); chk("sub_aluctl", ALUControl, 32'd1);
    chk("sub_srcb", ALUSrcB, 32'd0);
    tick(); chk("sub_aluwb", state_o, 32'd8); chk("sub_regwrite", RegWrite, 32'd1);
    chk("sub_retired", instr_retired, 32'd1);
    op = 7'b0010011;
    tick(); chk("sub_done", state_o, 32'd0);

    // addi with funct7 bit set is still add
    tick(); tick(); chk("addi_execi", state_o, 32'd7); chk("addi_aluctl", ALUControl, 32'd0);
    chk("addi_srcb", ALUSrcB, 32'd1);
    tick(); tick(); chk("addi_done", state_o, 32'd0);

    // slt
    op = 7'b0110011; funct3 = 3'b010; funct7 = 1'b0;
    tick(); tick(); chk("slt_aluctl", ALUControl, 32'd5);
    tick(); tick(); chk("slt_done", state_o, 32'd0);

    // beq taken
    op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1; #1;
    chk("beq_immsrc", ImmSrc, 32'd2);
    tick(); tick(); chk("beq_state", state_o, 32'd9); chk("beq_pcwrite", PCWrite, 32'd1);
    chk("beq_aluctl", ALUControl, 32'd1); chk("beq_retired", instr_retired, 32'd1);
    tick(); chk("beq_done", state_o, 32'd0);

    // bne taken with EN_BNE = 1, never with EN_BNE = 0
    funct3 = 3'b001; Zero = 1'b0;
    tick(); tick(); chk("bne_state", state_o, 32'd9); chk("bne_pcwrite", PCWrite, 32'd1);
    chk("bne_dis_pcwrite", b_PCWrite, 32'd0);
    tick(); chk("bne_done", state_o, 32'd0); chk("bne_dis_done", b_state_o, 32'd0);

    // jalr
    op = 7'b1100111; funct3 = 3'b000;
    tick(); chk("jalr_decode", state_o, 32'd1); chk("jalr_dec_pcwrite", PCWrite, 32'd0);
    tick(); chk("jalr_state", state_o, 32'd11); chk("jalr_pcwrite", PCWrite, 32'd1);
    chk("jalr_resultsrc", ResultSrc, 32'd2);
    tick(); chk("jlink_state", state_o, 32'd12); chk("jlink_pcwrite", PCWrite, 32'd0);
    chk("jlink_srca", ALUSrcA, 32'd1);
    tick(); chk("jalr_aluwb", state_o, 32'd8); chk("jalr_regwrite", RegWrite, 32'd1);
    op = 7'b0001111;
    tick(); chk("jalr_done", state_o, 32'd0);

    // illegal opcode
    tick(); chk("ill_decode", state_o, 32'd1);
    tick(); chk("ill_state", state_o, 32'd13); chk("ill_pulse", illegal_instr, 32'd1);
    chk("ill_regwrite", RegWrite, 32'd0); chk("ill_memwrite", MemWrite, 32'd0);
    chk("ill_pcwrite", PCWrite, 32'd0); chk("ill_retired", instr_retired, 32'd0);
    op = 7'b0100011; funct3 = 3'b010;
    tick(); chk("ill_done", state_o, 32'd0); chk("ill_pulse_end", illegal_instr, 32'd0);
    chk("sw_immsrc", ImmSrc, 32'd1);

    // sw with a runaway stall in MEMWRITE
    tick(); tick(); chk("sw_memadr", state_o, 32'd2);
    Stall = 1'b1;
    tick(); chk("sw_mw1", state_o, 32'd5); chk("sw_mw1_memwrite", MemWrite, 32'd1);
    chk("sw_mw1_retired", instr_retired, 32'd0);
    tick(); tick(); tick(); chk("sw_3stall_timeout", stall_timeout, 32'd0);
    tick(); chk("sw_4stall_timeout", stall_timeout, 32'd1); chk("sw_mw5_state", state_o, 32'd5);
    chk("sw_mw5_memwrite", MemWrite, 32'd1);
    tick(); chk("sw_timeout_sticky", stall_timeout, 32'd1); chk("sw_mw6_memwrite", MemWrite, 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("mid_rst_state", state_o, 32'd0);
    chk("mid_rst_memwrite", MemWrite, 32'd0);
    chk("mid_rst_memread", MemRead, 32'd0);
    chk("mid_rst_timeout", stall_timeout, 32'd0);
    #10;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
